// File: rtl/debug_uart_dumper_pkg.sv
// Shared constants for the debug UART dumper: FSM encodings, separator ASCII codes and the
// nibble-to-ASCII hex conversion.
package debug_uart_dumper_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StCapture,
    StSendHex,
    StSendSep,
    StNext,
    StFinish
  } state_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;

  // 0-9 -> '0'..'9', A-F -> 'A'..'F' (uppercase)
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/debug_uart_dumper_uart_tx.sv
// UART 8N1 transmitter with a valid/ready byte handshake.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   data, valid  : byte offered by the producer
//   ready        : high while idle; a byte is taken on the edge where valid && ready
//   tx           : serial line, idle high; start bit, 8 data bits LSB first, stop bit
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(CLKS_PER_BIT - 1);

  logic              active_q, active_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        frame_q, frame_d;

  always_comb begin
    active_d  = active_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    if (!active_q) begin
      if (valid) begin
        // Frame is shifted out LSB first: start bit, data, stop bit.
        frame_d   = {1'b1, data, 1'b0};
        active_d  = 1'b1;
        timer_d   = '0;
        bit_cnt_d = '0;
      end
    end else if (timer_q == TimerLast) begin
      timer_d = '0;
      frame_d = {1'b1, frame_q[9:1]};
      if (bit_cnt_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_q  <= 1'b0;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '1;
    end else begin
      active_q  <= active_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
    end
  end

  assign ready = !active_q;
  assign tx    = active_q ? frame_q[0] : 1'b1;

endmodule

// File: rtl/debug_uart_dumper.sv
// Debug-bus dumper: on start, sweeps debug_addr over 0..NUM_WORDS-1, captures each 32-bit
// debug_data word and prints it as 8 uppercase hex chars over UART, separated by spaces and
// CR LF every WORDS_PER_LINE words (and after the last word).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : dump request, ignored unless idle
//   debug_data   : word at debug_addr
//   debug_addr   : debug read address
//   tx           : UART serial line
//   busy         : dump in progress
//   done         : one-cycle pulse after the final stop bit
module debug_uart_dumper
  import debug_uart_dumper_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned NUM_WORDS      = 128,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned SETTLE_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] debug_data,
  output logic [6:0]  debug_addr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LastIndex  = 8'(NUM_WORDS - 1);

  state_e      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  col_q, col_d;
  logic [3:0]  settle_q, settle_d;
  logic [31:0] shift_q, shift_d;
  logic [3:0]  nib_q, nib_d;
  logic        cr_sent_q, cr_sent_d;
  logic        done_q, done_d;

  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       is_last, line_end;

  assign is_last  = (index_q == LastIndex);
  assign line_end = is_last || ({24'd0, col_q} == WORDS_PER_LINE - 1);

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    col_d     = col_q;
    settle_d  = settle_q;
    shift_d   = shift_q;
    nib_d     = nib_q;
    cr_sent_d = cr_sent_q;
    done_d    = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = nibble_to_ascii(shift_q[31:28]);
    unique case (state_q)
      StIdle: begin
        // done_q marks the cycle where a start would coincide with done; drop it.
        if (start && !done_q) begin
          index_d  = '0;
          col_d    = '0;
          settle_d = SettleLoad;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        // Sample on the edge leaving SETTLE so data is taken exactly SETTLE_CYCLES
        // edges after the address changed.
        if (settle_q == 4'd0) begin
          shift_d = debug_data;
          state_d = StCapture;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StCapture: begin
        nib_d   = 4'd8;
        state_d = StSendHex;
      end
      StSendHex: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          shift_d = {shift_q[27:0], 4'h0};
          nib_d   = nib_q - 4'd1;
          if (nib_q == 4'd1) begin
            cr_sent_d = 1'b0;
            state_d   = StSendSep;
          end
        end
      end
      StSendSep: begin
        tx_valid = 1'b1;
        if (line_end) begin
          tx_data = cr_sent_q ? AsciiLf : AsciiCr;
        end else begin
          tx_data = AsciiSpace;
        end
        if (tx_ready) begin
          if (line_end && !cr_sent_q) begin
            cr_sent_d = 1'b1;
          end else begin
            state_d = is_last ? StFinish : StNext;
          end
        end
      end
      StNext: begin
        index_d  = index_q + 8'd1;
        col_d    = line_end ? 8'd0 : col_q + 8'd1;
        settle_d = SettleLoad;
        state_d  = StSettle;
      end
      StFinish: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      index_q   <= '0;
      col_q     <= '0;
      settle_q  <= '0;
      shift_q   <= '0;
      nib_q     <= '0;
      cr_sent_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      shift_q   <= shift_d;
      nib_q     <= nib_d;
      cr_sent_q <= cr_sent_d;
      done_q    <= done_d;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clock(clock),
    .reset(reset),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (tx)
  );

  assign debug_addr = index_q[6:0];
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_debug_uart_dumper.sv
module tb_debug_uart_dumper;

  localparam int CPB = 4;
  typedef logic [7:0] byte_t;
  typedef byte_t byte_q_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0, start5 = 1'b0, start128 = 1'b0;
  logic [6:0] addr1, addr5, addr128;
  logic tx1, tx5, tx128, busy1, busy5, busy128, done1, done5, done128;
  logic [31:0] data1, data5, data128;

  int n_compared = 0;
  int n_mismatched = 0;

  byte_t q1[$], q5[$], q128[$];
  logic trace[$];

  always #5 clock = ~clock;

  assign data1   = 32'hDEAD0000 | {25'd0, addr1};
  assign data5   = 32'hDEAD0000 | {25'd0, addr5};
  assign data128 = 32'hDEAD0000 | {25'd0, addr128};

  debug_uart_dumper #(.CLKS_PER_BIT(CPB), .NUM_WORDS(1), .WORDS_PER_LINE(4),
                      .SETTLE_CYCLES(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .debug_data(data1),
    .debug_addr(addr1), .tx(tx1), .busy(busy1), .done(done1));

  debug_uart_dumper #(.CLKS_PER_BIT(CPB), .NUM_WORDS(5), .WORDS_PER_LINE(4),
                      .SETTLE_CYCLES(2)) u_dut5 (
    .clock(clock), .reset(reset), .start(start5), .debug_data(data5),
    .debug_addr(addr5), .tx(tx5), .busy(busy5), .done(done5));

  debug_uart_dumper #(.CLKS_PER_BIT(CPB), .NUM_WORDS(128), .WORDS_PER_LINE(4),
                      .SETTLE_CYCLES(2)) u_dut128 (
    .clock(clock), .reset(reset), .start(start128), .debug_data(data128),
    .debug_addr(addr128), .tx(tx128), .busy(busy128), .done(done128));

  function automatic logic get_tx(input int id);
    case (id)
      0:       return tx1;
      1:       return tx5;
      default: return tx128;
    endcase
  endfunction

  function automatic void push_byte(input int id, input byte_t b);
    case (id)
      0:       q1.push_back(b);
      1:       q5.push_back(b);
      default: q128.push_back(b);
    endcase
  endfunction

  // Samples each bit near its middle (cycle 2 of 4).
  task automatic uart_monitor(input int id);
    byte_t b;
    forever begin
      @(negedge clock);
      if (get_tx(id) === 1'b0) begin
        repeat (CPB / 2) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          b[i] = get_tx(id);
        end
        repeat (CPB) @(negedge clock);
        push_byte(id, b);
      end
    end
  endtask

  initial uart_monitor(0);
  initial uart_monitor(1);
  initial uart_monitor(2);

  // Expected stream built from the word values 32'hDEAD0000 | w.
  function automatic byte_q_t build_exp(input int n, input int wpl);
    byte_q_t e;
    string hexd = "0123456789ABCDEF";
    logic [31:0] v;
    for (int w = 0; w < n; w++) begin
      v = 32'hDEAD0000 | 32'(w);
      for (int k = 7; k >= 0; k--) e.push_back(hexd[v[k*4 +: 4]]);
      if (w == n - 1 || ((w + 1) % wpl) == 0) begin
        e.push_back(8'h0D);
        e.push_back(8'h0A);
      end else begin
        e.push_back(8'h20);
      end
    end
    return e;
  endfunction

  task automatic pulse(input int id);
    @(negedge clock);
    case (id)
      0: start1 = 1'b1;
      1: start5 = 1'b1;
      default: start128 = 1'b1;
    endcase
    @(negedge clock);
    start1 = 1'b0;
    start5 = 1'b0;
    start128 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_compared++;
    if ({tx1, busy1, done1, addr1} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      n_mismatched++;
      $display("FAIL reset_dut1: got tx/busy/done/addr %b%b%b/%0d want 100/0",
               tx1, busy1, done1, addr1);
    end
    n_compared++;
    if ({tx5, busy5, done5, addr5} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      n_mismatched++;
      $display("FAIL reset_dut5: got tx/busy/done/addr %b%b%b/%0d want 100/0",
               tx5, busy5, done5, addr5);
    end
    n_compared++;
    if ({tx128, busy128, done128, addr128} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      n_mismatched++;
      $display("FAIL reset_dut128: got tx/busy/done/addr %b%b%b/%0d want 100/0",
               tx128, busy128, done128, addr128);
    end
  endtask

  task automatic test_single_word;
    byte_q_t e;
    int cyc;
    int bad;
    e = build_exp(1, 4);
    q1.delete();
    trace.delete();
    pulse(0);
    n_compared++;
    if ({busy1, addr1} !== {1'b1, 7'd0}) begin
      n_mismatched++;
      $display("FAIL single_busy_after_start: got busy=%b addr=%0d want busy=1 addr=0",
               busy1, addr1);
    end
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 1000) begin
      trace.push_back(tx1);
      @(negedge clock);
      cyc++;
    end
    n_compared++;
    if (done1 !== 1'b1) begin
      n_mismatched++;
      $display("FAIL single_done_seen: got done=%b after %0d cycles want 1", done1, cyc);
    end
    @(negedge clock);
    n_compared++;
    if ({done1, busy1} !== 2'b00) begin
      n_mismatched++;
      $display("FAIL single_done_width: got done=%b busy=%b want 0 0", done1, busy1);
    end
    repeat (10) @(negedge clock);
    bad = -1;
    for (int i = 0; i < e.size(); i++)
      if (bad < 0 && (i >= q1.size() || q1[i] !== e[i])) bad = i;
    n_compared++;
    if (bad >= 0 || q1.size() != e.size()) begin
      n_mismatched++;
      $display("FAIL single_stream: first bad byte %0d got %02h want %02h, got len %0d want %0d",
               bad, (bad >= 0 && bad < q1.size()) ? q1[bad] : 8'hxx,
               (bad >= 0) ? e[bad] : 8'hxx, q1.size(), e.size());
    end
  endtask

  // Third byte of the single dump is 'A' (0x41).
  task automatic test_bit_timing;
    int i;
    logic bv;
    logic [7:0] a;
    a = 8'h41;
    i = 0;
    for (int f = 0; f < 3; f++) begin
      while (i < trace.size() && trace[i] !== 1'b0) i++;
      if (f < 2) i += 10 * CPB;
    end
    for (int b = 0; b < 10; b++) begin
      bv = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : a[b-1];
      for (int c = 0; c < CPB; c++) begin
        if (c == 0) n_compared++;
        if (i + b * CPB + c >= trace.size() || trace[i+b*CPB+c] !== bv) begin
          n_mismatched++;
          $display("FAIL bit_timing_bit%0d: cycle %0d got %b want %b", b, c,
                   (i + b * CPB + c < trace.size()) ? trace[i+b*CPB+c] : 1'bx, bv);
          break;
        end
      end
    end
  endtask

  task automatic test_line_breaks;
    byte_q_t e;
    int vals[$];
    int lens[$];
    int cyc;
    int bad;
    e = build_exp(5, 4);
    q5.delete();
    pulse(1);
    vals.push_back(int'(addr5));
    lens.push_back(1);
    cyc = 0;
    while (done5 !== 1'b1 && cyc < 5000) begin
      @(negedge clock);
      cyc++;
      if (int'(addr5) != vals[$]) begin
        vals.push_back(int'(addr5));
        lens.push_back(1);
      end else begin
        lens[$] = lens[$] + 1;
      end
    end
    // start coinciding with done must be ignored
    start5 = 1'b1;
    @(negedge clock);
    start5 = 1'b0;
    n_compared++;
    if (busy5 !== 1'b0) begin
      n_mismatched++;
      $display("FAIL start_on_done_ignored: got busy=%b want 0", busy5);
    end
    n_compared++;
    if (vals.size() != 5) begin
      n_mismatched++;
      $display("FAIL addr_step_count: got %0d addresses want 5", vals.size());
    end
    for (int k = 0; k < vals.size() && k < 5; k++) begin
      n_compared++;
      if (vals[k] != k || lens[k] < 2) begin
        n_mismatched++;
        $display("FAIL addr_step%0d: got addr %0d held %0d want addr %0d held >=2",
                 k, vals[k], lens[k], k);
      end
    end
    repeat (10) @(negedge clock);
    bad = -1;
    for (int i = 0; i < e.size(); i++)
      if (bad < 0 && (i >= q5.size() || q5[i] !== e[i])) bad = i;
    n_compared++;
    if (bad >= 0 || q5.size() != e.size()) begin
      n_mismatched++;
      $display("FAIL line_stream: first bad byte %0d got %02h want %02h, got len %0d want %0d",
               bad, (bad >= 0 && bad < q5.size()) ? q5[bad] : 8'hxx,
               (bad >= 0) ? e[bad] : 8'hxx, q5.size(), e.size());
    end
  endtask

  task automatic test_start_while_busy;
    byte_q_t e;
    int dones;
    int first_done;
    int bad;
    e = build_exp(5, 4);
    q5.delete();
    pulse(1);
    dones = 0;
    first_done = -1;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clock);
      if (cyc == 100) start5 = 1'b1;
      if (cyc == 101) start5 = 1'b0;
      if (done5 === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = cyc;
      end
      if (first_done >= 0 && cyc > first_done + 600) break;
    end
    n_compared++;
    if (dones != 1) begin
      n_mismatched++;
      $display("FAIL busy_start_done_count: got %0d done pulses want 1", dones);
    end
    bad = -1;
    for (int i = 0; i < e.size(); i++)
      if (bad < 0 && (i >= q5.size() || q5[i] !== e[i])) bad = i;
    n_compared++;
    if (bad >= 0 || q5.size() != e.size()) begin
      n_mismatched++;
      $display("FAIL busy_start_stream: first bad byte %0d, got len %0d want %0d",
               bad, q5.size(), e.size());
    end
  endtask

  task automatic test_reset_mid_byte;
    byte_q_t e;
    int cyc;
    int bad;
    e = build_exp(5, 4);
    pulse(1);
    cyc = 0;
    while (addr5 != 7'd2 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    while (tx5 !== 1'b0 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    // move into data bit 2, mid-bit
    repeat (CPB * 3 + 1) @(negedge clock);
    n_compared++;
    if (busy5 !== 1'b1 || addr5 != 7'd2) begin
      n_mismatched++;
      $display("FAIL reset_mid_setup: got busy=%b addr=%0d want busy=1 addr=2", busy5, addr5);
    end
    reset = 1'b1;
    @(negedge clock);
    n_compared++;
    if ({tx5, busy5, done5, addr5} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
      n_mismatched++;
      $display("FAIL reset_mid_outputs: got tx/busy/done/addr %b%b%b/%0d want 100/0",
               tx5, busy5, done5, addr5);
    end
    reset = 1'b0;
    repeat (60) @(negedge clock);
    q5.delete();
    pulse(1);
    cyc = 0;
    while (done5 !== 1'b1 && cyc < 5000) begin
      @(negedge clock);
      cyc++;
    end
    repeat (10) @(negedge clock);
    bad = -1;
    for (int i = 0; i < e.size(); i++)
      if (bad < 0 && (i >= q5.size() || q5[i] !== e[i])) bad = i;
    n_compared++;
    if (bad >= 0 || q5.size() != e.size()) begin
      n_mismatched++;
      $display("FAIL reset_restart_stream: first bad byte %0d, got len %0d want %0d",
               bad, q5.size(), e.size());
    end
  endtask

  task automatic test_full_sweep;
    byte_q_t e;
    int dones;
    int wraps;
    int cyc;
    int bad;
    logic [6:0] prev;
    e = build_exp(128, 4);
    q128.delete();
    pulse(2);
    prev = addr128;
    dones = 0;
    wraps = 0;
    cyc = 0;
    while (dones == 0 && cyc < 60000) begin
      @(negedge clock);
      cyc++;
      if (addr128 < prev) wraps++;
      prev = addr128;
      if (done128 === 1'b1) dones++;
    end
    repeat (50) begin
      @(negedge clock);
      if (done128 === 1'b1) dones++;
    end
    n_compared++;
    if (dones != 1) begin
      n_mismatched++;
      $display("FAIL sweep_done_count: got %0d want 1", dones);
    end
    n_compared++;
    if (wraps != 0 || addr128 != 7'd127) begin
      n_mismatched++;
      $display("FAIL sweep_addr: got %0d wraps, final addr %0d want 0 wraps, addr 127",
               wraps, addr128);
    end
    n_compared++;
    if (q128.size() != e.size()) begin
      n_mismatched++;
      $display("FAIL sweep_len: got %0d bytes want %0d", q128.size(), e.size());
    end
    bad = -1;
    for (int i = 0; i < 10; i++) begin
      if (bad < 0 && (q128.size() < 10 ||
                      q128[q128.size()-10+i] !== e[e.size()-10+i])) bad = i;
    end
    n_compared++;
    if (bad >= 0) begin
      n_mismatched++;
      $display("FAIL sweep_last_word: tail byte %0d got %02h want %02h", bad,
               (q128.size() >= 10) ? q128[q128.size()-10+bad] : 8'hxx, e[e.size()-10+bad]);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bit_timing();
    test_line_breaks();
    test_start_while_busy();
    test_reset_mid_byte();
    test_full_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
